// File: rtl/mux2_1_1bit_arbiter_if.sv
// Bus bundle between the two bit-serial requesters and the shared 2:1 mux arbiter.
// The master side drives requests and data bits. The slave side is the arbiter.
interface mux2_1_1bit_arbiter_if;
  logic req0;
  logic req1;
  logic in1;
  logic in2;
  logic gnt0;
  logic gnt1;
  logic selec;
  logic out_data;
  logic out_valid;

  modport master (
    output req0, req1, in1, in2,
    input  gnt0, gnt1, selec, out_data, out_valid
  );

  modport slave (
    input  req0, req1, in1, in2,
    output gnt0, gnt1, selec, out_data, out_valid
  );
endinterface

// File: rtl/mux2_1_1bit_arbiter.sv
// Round-robin arbiter for a shared 2:1 1-bit mux. It grants bounded bursts and
// registers the selected bit as a valid output stream.
module mux2_1_1bit_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  mux2_1_1bit_arbiter_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GNT0 = 2'd1,
    S_GNT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             last_served;
  logic             selec_p1;
  logic             data_p1;
  logic             vld_p1;

  logic own_req;
  logic oth_req;
  logic beat;
  logic grant_end;
  logic sel_bit;

  // The counter stops at the last beat index instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_LAST) ? CNT_LAST : c + 1'b1;
  endfunction

  always_comb begin
    own_req   = 1'b0;
    oth_req   = 1'b0;
    beat      = 1'b0;
    grant_end = 1'b0;
    sel_bit   = selec_p1 ? bus.in2 : bus.in1;
    if (state == S_GNT0) begin
      own_req = bus.req0;
      oth_req = bus.req1;
    end else if (state == S_GNT1) begin
      own_req = bus.req1;
      oth_req = bus.req0;
    end
    if (state != S_IDLE) begin
      beat      = own_req;
      grant_end = !own_req || (cnt == CNT_LAST);
    end
  end

  // Stage p0 -> p1: arbitration state, mux select and captured beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_served <= 1'b1;
      selec_p1    <= 1'b0;
      data_p1     <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (beat) begin
        data_p1 <= sel_bit;
        vld_p1  <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.req0 && bus.req1) begin
            state    <= last_served ? S_GNT0 : S_GNT1;
            selec_p1 <= !last_served;
          end else if (bus.req0) begin
            state    <= S_GNT0;
            selec_p1 <= 1'b0;
          end else if (bus.req1) begin
            state    <= S_GNT1;
            selec_p1 <= 1'b1;
          end
        end
        S_GNT0, S_GNT1: begin
          if (grant_end) begin
            last_served <= (state == S_GNT1);
            cnt         <= '0;
            // Handing off straight to the waiting requester avoids an IDLE bubble.
            if (oth_req) begin
              state    <= (state == S_GNT0) ? S_GNT1 : S_GNT0;
              selec_p1 <= (state == S_GNT0);
            end else if (own_req) begin
              state    <= state;
              selec_p1 <= (state == S_GNT1);
            end else begin
              state <= S_IDLE;
            end
          end else if (beat) begin
            cnt <= cnt_inc(cnt);
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.gnt0      = (state == S_GNT0);
  assign bus.gnt1      = (state == S_GNT1);
  assign bus.selec     = selec_p1;
  assign bus.out_data  = data_p1;
  assign bus.out_valid = vld_p1;

  a_grant_onehot : assert property (@(posedge clk) !(bus.gnt0 && bus.gnt1));
  a_cnt_bound    : assert property (@(posedge clk) cnt <= CNT_LAST);

endmodule

// File: tb/tb_mux2_1_1bit_arbiter.sv
// Directed self-checking bench for the 2:1 mux round-robin arbiter.
module tb_mux2_1_1bit_arbiter;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [4:0] obs;
  logic [4:0] exp_v;

  mux2_1_1bit_arbiter_if bus();

  mux2_1_1bit_arbiter #(.MAX_BURST(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // obs = {gnt0, gnt1, selec, out_valid, out_data}
  task automatic tick();
    @(posedge clk);
    #1;
    obs = {bus.gnt0, bus.gnt1, bus.selec, bus.out_valid, bus.out_data};
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.in1 = 1'b0; bus.in2 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.in1 = 1'b1; bus.in2 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== 5'b00000) begin
        failures++;
        $display("FAIL reset_hold cycle=%0d got=%b exp=%b", i, obs, 5'b00000);
      end
    end
    reset = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("FAIL reset_after got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_single_req0();
    logic [4:0] tbl [5];
    logic       din [5];
    tbl = '{5'b10000, 5'b10011, 5'b10010, 5'b10011, 5'b00001};
    din = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req0 = (i < 4);
      bus.in1  = din[i];
      tick();
      checks++;
      if (obs !== tbl[i]) begin
        failures++;
        $display("FAIL single_req0 edge=%0d got=%b exp=%b", i + 1, obs, tbl[i]);
      end
    end
    bus.req0 = 1'b0;
  endtask

  task automatic test_tie_round_robin();
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.in1 = 1'b1; bus.in2 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_v[4] = (i <= 8) || (i >= 17);
      exp_v[3] = (i >= 9) && (i <= 16);
      exp_v[2] = exp_v[3];
      exp_v[1] = (i >= 2);
      exp_v[0] = (i >= 2) && !((i >= 10) && (i <= 17));
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL tie_rr edge=%0d got=%b exp=%b", i, obs, exp_v);
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  task automatic test_burst_expiry();
    int exp_cnt;
    apply_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      bus.in1 = (i % 3 == 0);
      tick();
      exp_v = (i == 1) ? 5'b10000 : {4'b1001, (i % 3 == 0)};
      exp_cnt = (i == 1) ? 0 : ((i - 1 < 8) ? i - 1 : i - 9);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL burst_out edge=%0d got=%b exp=%b", i, obs, exp_v);
      end
      checks++;
      if (dut.cnt !== 4'(exp_cnt)) begin
        failures++;
        $display("FAIL burst_cnt edge=%0d got=%0d exp=%0d", i, dut.cnt, exp_cnt);
      end
    end
    bus.req0 = 1'b0;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("FAIL burst_idle got=%b exp=%b", obs, 5'b00000);
    end
  endtask

  task automatic test_single_req1();
    logic [4:0] tbl [6];
    logic       din [6];
    tbl = '{5'b01100, 5'b01111, 5'b01111, 5'b01110, 5'b01111, 5'b00101};
    din = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      bus.req1 = (i < 5);
      bus.in2  = din[i];
      tick();
      checks++;
      if (obs !== tbl[i]) begin
        failures++;
        $display("FAIL single_req1 edge=%0d got=%b exp=%b", i + 1, obs, tbl[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    bus.req1 = 1'b1; bus.in2 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (obs !== 5'b01111) begin
      failures++;
      $display("FAIL midrst_pre got=%b exp=%b", obs, 5'b01111);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b00000) begin
      failures++;
      $display("FAIL midrst_abort got=%b exp=%b", obs, 5'b00000);
    end
    reset = 1'b0;
    bus.req0 = 1'b1; bus.in1 = 1'b1;
    tick();
    checks++;
    if (obs !== 5'b10000) begin
      failures++;
      $display("FAIL midrst_tie got=%b exp=%b", obs, 5'b10000);
    end
    tick();
    checks++;
    if (obs !== 5'b10011) begin
      failures++;
      $display("FAIL midrst_beat got=%b exp=%b", obs, 5'b10011);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.in1 = 1'b0; bus.in2 = 1'b0;
    test_reset();
    test_single_req0();
    test_tie_round_robin();
    test_burst_expiry();
    test_single_req1();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux2_1_1bit_arbiter.md
# mux2_1_1bit_arbiter

Round-robin arbiter and sequencer for the shared 2:1 1-bit multiplexer. Two requesters compete for the mux output. The block grants one requester at a time, drives the mux select, and registers the selected data bit as a valid output stream. A grant lasts for a bounded burst. The block sits between the two bit-serial sources and the single downstream consumer of the mux output.

## Interface
- MAX_BURST, 8, maximum beats per grant before forced re-arbitration (≥1).
- CNT_W, 4, burst counter width; must satisfy 2^CNT_W ≥ MAX_BURST.
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants the mux; source data on in1.
- req1  input  1  requester 1 wants the mux; source data on in2.
- in1  input  1  data bit from requester 0 (mux input selected by selec=0).
- in2  input  1  data bit from requester 1 (mux input selected by selec=1).
- gnt0  output  1  requester 0 owns the mux.
- gnt1  output  1  requester 1 owns the mux.
- selec  output  1  mux select: 0 → in1, 1 → in2.
- out_data  output  1  registered mux output bit.
- out_valid  output  1  out_data carries a transferred beat.

## Operation
- The FSM has three states: IDLE, GNT0, GNT1.
- gnt0 = (state==GNT0) and gnt1 = (state==GNT1). The two grants are one-hot or both 0, and are never both 1.
- selec is a register:
  - Loaded to 0 on entry to GNT0 and to 1 on entry to GNT1.
  - Holds its last value in IDLE.
- last_served is an internal register that records the requester whose grant ended most recently.
- IDLE transitions:
  - req0 & req1 → grant the requester ≠ last_served.
  - Only req0 → GNT0. Only req1 → GNT1.
  - No request → stay in IDLE.
- Beat definition: a beat is a cycle with state==GNTx and reqx=1.
  - At the closing edge of a beat: out_data ← selected input, out_valid ← 1, cnt ← cnt+1.
  - Any non-beat cycle: out_valid ← 0, and out_data holds its value.
- Grant end in GNTx is taken at the edge where either:
  - reqx=0 (no beat is taken), or
  - a beat occurs with cnt==MAX_BURST-1 (that final beat is transferred).
- On grant end: last_served ← x and cnt ← 0, then:
  - Other requester's req=1 → go directly to the other grant, with no IDLE bubble.
  - Else reqx=1 (burst expired, no contention) → re-enter GNTx.
  - Else → IDLE.
- cnt never exceeds MAX_BURST-1 and never wraps silently.
- A requester must hold its input bit valid during every cycle in which it is granted and keeps req high.

## Timing
- Reset values (applied at the first clock edge with reset=1, overriding everything):
  - state=IDLE, gnt0=0, gnt1=0, selec=0, out_data=0, out_valid=0.
  - cnt=0, last_served=1, so requester 0 wins the first tie.
- Latency from request to output:
  - req sampled at edge k while IDLE → gnt high after edge k.
  - First beat captured at edge k+1 → out_valid=1 after edge k+1.
  - Total: 2 cycles from req to out_valid.
- out_data/out_valid lag their beat by exactly one cycle.
- Throughput: one bit per cycle. Back-to-back handoff between requesters has zero dead cycles in grant. out_valid shows no gap if the new owner requests continuously.
- Simultaneous events:
  - req drop and burst expiry cannot coincide: a beat requires req=1.
  - Reset asserted mid-burst aborts the burst. The next cycle shows reset values, and the partial burst is not completed.
- All outputs are registers or pure state decodes. There are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert reset for 2 cycles with req0=req1=1 → during reset and one cycle after, gnt0=gnt1=0, selec=0, out_valid=0, out_data=0.
- Single requester: req0=1 for 3 cycles with in1=1,0,1 → gnt0 rises 1 cycle after req0; out_valid=1 for 3 consecutive cycles with out_data=1,0,1; selec=0; then IDLE, out_valid=0.
- Tie from reset, MAX_BURST=8: req0=req1=1 held for 20 cycles →
  - gnt0 for exactly 8 beats, then gnt1 on the next cycle (no IDLE).
  - Then gnt1 for 8 beats, then gnt0 for the remaining beats.
  - out_valid stays continuously 1.
- Burst expiry without contention: req0=1 for 10 cycles, req1=0 → gnt0 stays continuously 1; 10 valid beats; internal cnt restarts at 0 after beat 8.
- Requester 1 alone: req1=1 for 4 cycles with in2=1,1,0,1 → selec=1, out_data=1,1,0,1; after req1 drops, state is IDLE and selec remains 1.
- Reset mid-burst: reset=1 at the 4th beat of gnt1 → next cycle gnt1=0, out_valid=0, selec=0; after release with req0=req1=1, gnt0 wins.
